// File: rtl/cla_topic_buf_alloc_arb.sv
// cla_topic_buf_alloc_arb: round-robin sharing of the free list alloc/release ports,
// plus init/re-init sequencing and outstanding-buffer accounting.
module cla_topic_buf_alloc_arb #(
  parameter int BPTR_NBITS = 8,
  parameter int NREQ       = 4,
  parameter int NREL       = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            alloc_req,
  output logic [NREQ-1:0]            alloc_gnt,
  output logic [BPTR_NBITS-1:0]      alloc_ptr,
  input  logic [NREL-1:0]            rel_req,
  input  logic [NREL*BPTR_NBITS-1:0] rel_ptr,
  output logic [NREL-1:0]            rel_ack,
  input  logic                       sw_init,
  output logic                       free_buf_rd,
  input  logic [BPTR_NBITS-1:0]      free_buf_ptr,
  input  logic                       freeb_empty,
  input  logic                       freeb_init_done,
  output logic                       freeb_init,
  output logic                       rel_buf_valid,
  output logic [BPTR_NBITS-1:0]      rel_buf_ptr,
  output logic [BPTR_NBITS:0]        inuse_count,
  output logic                       rel_err,
  output logic                       busy
);
  localparam int AW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int RW = NREL > 1 ? $clog2(NREL) : 1;
  localparam logic [BPTR_NBITS:0] CNT_MAX = {1'b1, {BPTR_NBITS{1'b0}}};
  typedef enum logic [1:0] {WAIT_INIT, RUN, REINIT_REQ, REINIT_WAIT} state_e;
  state_e                  state_q;
  logic [NREQ-1:0]         alloc_gnt_q, a_elig;
  logic [NREL-1:0]         rel_ack_q, r_elig;
  logic [BPTR_NBITS-1:0]   alloc_ptr_q, rel_ptr_q;
  logic [AW-1:0]           rr_a_q, a_win;
  logic [RW-1:0]           rr_r_q, r_win;
  logic                    a_any, r_any, r_fire, r_fwd, pop;
  logic                    rel_valid_q, finit_q, err_q, err_d;
  logic [BPTR_NBITS:0]     cnt_q, cnt_d;
  assign a_elig = alloc_req & ~alloc_gnt_q;
  assign r_elig = rel_req & ~rel_ack_q;
  // Descending scan so the last hit is the first eligible client after the rr pointer.
  always_comb begin
    a_win = rr_a_q;
    a_any = 1'b0;
    for (int i = NREQ; i >= 1; i--)
      if (a_elig[(int'(rr_a_q) + i) % NREQ]) begin
        a_win = AW'((int'(rr_a_q) + i) % NREQ);
        a_any = 1'b1;
      end
  end
  always_comb begin
    r_win = rr_r_q;
    r_any = 1'b0;
    for (int i = NREL; i >= 1; i--)
      if (r_elig[(int'(rr_r_q) + i) % NREL]) begin
        r_win = RW'((int'(rr_r_q) + i) % NREL);
        r_any = 1'b1;
      end
  end
  assign pop         = (state_q == RUN) && a_any && !freeb_empty && freeb_init_done;
  assign r_fire      = (state_q != WAIT_INIT) && r_any;
  assign r_fwd       = r_fire && (state_q == RUN);
  assign free_buf_rd = pop;
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == REINIT_WAIT && freeb_init_done) begin
      cnt_d = '0;
      err_d = 1'b0;
    end else if (pop && !r_fwd) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end else if (r_fwd && !pop) begin
      cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
      err_d = err_q | (cnt_q == '0);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_INIT;
      alloc_gnt_q <= '0;
      alloc_ptr_q <= '0;
      rel_ack_q   <= '0;
      rel_ptr_q   <= '0;
      rel_valid_q <= 1'b0;
      rr_a_q      <= '0;
      rr_r_q      <= '0;
      finit_q     <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      alloc_gnt_q <= pop ? NREQ'(1) << a_win : '0;
      rel_ack_q   <= r_fire ? NREL'(1) << r_win : '0;
      rel_valid_q <= r_fwd;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      if (pop) begin
        alloc_ptr_q <= free_buf_ptr;
        rr_a_q      <= a_win;
      end
      if (r_fire) rr_r_q <= r_win;
      if (r_fwd) rel_ptr_q <= rel_ptr[r_win*BPTR_NBITS +: BPTR_NBITS];
      case (state_q)
        WAIT_INIT: if (freeb_init_done) state_q <= RUN;
        RUN: if (sw_init) begin
          state_q <= REINIT_REQ;
          finit_q <= 1'b1;
        end
        REINIT_REQ: if (!freeb_init_done) begin
          state_q <= REINIT_WAIT;
          finit_q <= 1'b0;
        end
        default: if (freeb_init_done) state_q <= RUN;
      endcase
    end
  end
  assign alloc_gnt     = alloc_gnt_q;
  assign alloc_ptr     = alloc_ptr_q;
  assign rel_ack       = rel_ack_q;
  assign rel_buf_valid = rel_valid_q;
  assign rel_buf_ptr   = rel_ptr_q;
  assign freeb_init    = finit_q;
  assign inuse_count   = cnt_q;
  assign rel_err       = err_q;
  assign busy          = state_q != RUN;
endmodule

// File: tb/tb_cla_topic_buf_alloc_arb.sv
// tb_cla_topic_buf_alloc_arb: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the arbiter.
module tb_cla_topic_buf_alloc_arb;
  localparam int B = 8, NQ = 4, NL = 2;
  localparam int S_WAIT = 0, S_RUN = 1, S_RQ = 2, S_RW = 3;
  logic clk = 1'b0, rst = 1'b1;
  logic [NQ-1:0] alloc_req = '0, alloc_gnt;
  logic [B-1:0] alloc_ptr, free_buf_ptr = '0, rel_buf_ptr;
  logic [NL-1:0] rel_req = '0, rel_ack;
  logic [NL*B-1:0] rel_ptr = '0;
  logic sw_init = 1'b0, free_buf_rd, freeb_empty = 1'b0, freeb_init_done = 1'b0;
  logic freeb_init, rel_buf_valid, rel_err, busy;
  logic [B:0] inuse_count;
  int n_total = 0, n_bad = 0;
  int m_state, m_rr_a, m_rr_r, m_cnt;
  logic [NQ-1:0] m_gnt;
  logic [NL-1:0] m_ack;
  logic [B-1:0] m_ptr, m_rptr;
  logic m_rv, m_err, m_finit, m_rd, got_rd;

  always #5 clk = ~clk;

  cla_topic_buf_alloc_arb #(.BPTR_NBITS(B), .NREQ(NQ), .NREL(NL)) dut (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_ptr(alloc_ptr),
    .rel_req(rel_req), .rel_ptr(rel_ptr), .rel_ack(rel_ack), .sw_init(sw_init),
    .free_buf_rd(free_buf_rd), .free_buf_ptr(free_buf_ptr), .freeb_empty(freeb_empty),
    .freeb_init_done(freeb_init_done), .freeb_init(freeb_init), .rel_buf_valid(rel_buf_valid),
    .rel_buf_ptr(rel_buf_ptr), .inuse_count(inuse_count), .rel_err(rel_err), .busy(busy));

  function automatic int pick(logic [7:0] elig, int rr, int n);
    for (int k = 1; k <= n; k++) if (elig[(rr + k) % n]) return (rr + k) % n;
    return -1;
  endfunction

  task automatic model_tick();
    int wa, wr, c;
    bit fire, fwd;
    got_rd = free_buf_rd;
    if (rst) begin
      m_state = S_WAIT; m_rr_a = 0; m_rr_r = 0; m_cnt = 0; m_gnt = '0; m_ack = '0;
      m_ptr = '0; m_rptr = '0; m_rv = 0; m_err = 0; m_finit = 0; m_rd = 0;
      return;
    end
    wa = pick(8'(alloc_req & ~m_gnt), m_rr_a, NQ);
    wr = pick(8'(rel_req & ~m_ack), m_rr_r, NL);
    m_rd = m_state == S_RUN && wa >= 0 && !freeb_empty && freeb_init_done;
    fire = m_state != S_WAIT && wr >= 0;
    fwd = fire && m_state == S_RUN;
    m_gnt = m_rd ? NQ'(1 << wa) : '0;
    if (m_rd) begin m_ptr = free_buf_ptr; m_rr_a = wa; end
    m_ack = fire ? NL'(1 << wr) : '0;
    if (fire) m_rr_r = wr;
    m_rv = fwd;
    if (fwd) m_rptr = rel_ptr[wr*B +: B];
    c = m_cnt + int'(m_rd) - int'(fwd);
    if (c < 0) begin c = 0; m_err = 1; end
    if (c > (1 << B)) c = 1 << B;
    m_cnt = c;
    case (m_state)
      S_WAIT: if (freeb_init_done) m_state = S_RUN;
      S_RUN: if (sw_init) m_state = S_RQ;
      S_RQ: if (!freeb_init_done) m_state = S_RW;
      default: if (freeb_init_done) begin m_state = S_RUN; m_cnt = 0; m_err = 0; end
    endcase
    m_finit = m_state == S_RQ;
  endtask

  task automatic cyc();
    #2;
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc();
    n_total++; if ({alloc_gnt, alloc_ptr, rel_ack, rel_buf_valid, rel_buf_ptr, freeb_init, inuse_count, rel_err} !== '0) begin
      n_bad++; $display("FAIL reset_outputs got gnt=%b ptr=%h ack=%b rv=%b rptr=%h finit=%b cnt=%0d err=%b exp all 0",
        alloc_gnt, alloc_ptr, rel_ack, rel_buf_valid, rel_buf_ptr, freeb_init, inuse_count, rel_err);
    end
    n_total++; if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy got=%b exp=1", busy); end
    rst = 1'b0;
    alloc_req = '1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      n_total++; if (got_rd !== 1'b0 || busy !== 1'b1) begin
        n_bad++; $display("FAIL wait_init cyc=%0d got rd=%b busy=%b exp rd=0 busy=1", i, got_rd, busy);
      end
    end
    alloc_req = '0;
    freeb_init_done = 1'b1;
    cyc();
    n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL init_done_busy got=%b exp=0", busy); end
  endtask

  task automatic test_alloc_rr();
    logic [NQ-1:0] prev = '0;
    free_buf_ptr = 8'h00;
    alloc_req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (m_rd) free_buf_ptr++;
      n_total++; if (alloc_gnt !== NQ'(1 << ((i + 1) % NQ)) || alloc_ptr !== B'(i) || got_rd !== 1'b1) begin
        n_bad++; $display("FAIL alloc_rr i=%0d got gnt=%b ptr=%h rd=%b exp gnt=%b ptr=%h rd=1",
          i, alloc_gnt, alloc_ptr, got_rd, NQ'(1 << ((i + 1) % NQ)), B'(i));
      end
      n_total++; if ((alloc_gnt & prev) !== '0) begin
        n_bad++; $display("FAIL alloc_back_to_back got gnt=%b prev=%b exp disjoint", alloc_gnt, prev);
      end
      prev = alloc_gnt;
    end
    alloc_req = '0;
    n_total++; if (inuse_count !== 9'd4) begin n_bad++; $display("FAIL alloc_count got=%0d exp=4", inuse_count); end
  endtask

  task automatic test_empty();
    alloc_req = 4'b0100;
    freeb_empty = 1'b1;
    free_buf_ptr = 8'h3A;
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_total++; if (alloc_gnt !== '0 || got_rd !== 1'b0) begin
        n_bad++; $display("FAIL empty_hold i=%0d got gnt=%b rd=%b exp gnt=0 rd=0", i, alloc_gnt, got_rd);
      end
    end
    freeb_empty = 1'b0;
    cyc();
    alloc_req = '0;
    n_total++; if (got_rd !== 1'b1 || alloc_gnt !== 4'b0100 || alloc_ptr !== 8'h3A || inuse_count !== 9'd5) begin
      n_bad++; $display("FAIL empty_release got rd=%b gnt=%b ptr=%h cnt=%0d exp rd=1 gnt=0100 ptr=3a cnt=5",
        got_rd, alloc_gnt, alloc_ptr, inuse_count);
    end
  endtask

  task automatic test_rel_collide();
    free_buf_ptr = 8'h50;
    alloc_req = 4'b0001;
    rel_req = 2'b11;
    rel_ptr = {8'h20, 8'h10};
    cyc();
    alloc_req = '0;
    rel_req = 2'b01;
    n_total++; if (alloc_gnt !== 4'b0001 || rel_ack !== 2'b10 || rel_buf_valid !== 1'b1 || rel_buf_ptr !== 8'h20 || inuse_count !== 9'd5) begin
      n_bad++; $display("FAIL rel_first got gnt=%b ack=%b rv=%b rptr=%h cnt=%0d exp gnt=0001 ack=10 rv=1 rptr=20 cnt=5",
        alloc_gnt, rel_ack, rel_buf_valid, rel_buf_ptr, inuse_count);
    end
    cyc();
    rel_req = '0;
    n_total++; if (rel_ack !== 2'b01 || rel_buf_valid !== 1'b1 || rel_buf_ptr !== 8'h10 || inuse_count !== 9'd4) begin
      n_bad++; $display("FAIL rel_second got ack=%b rv=%b rptr=%h cnt=%0d exp ack=01 rv=1 rptr=10 cnt=4",
        rel_ack, rel_buf_valid, rel_buf_ptr, inuse_count);
    end
    cyc();
  endtask

  task automatic test_underflow();
    for (int k = 0; k < 5; k++) begin
      rel_req = 2'b01;
      rel_ptr = {8'h00, 8'(8'h40 + k)};
      cyc();
      rel_req = '0;
      n_total++; if (rel_buf_valid !== 1'b1 || rel_buf_ptr !== 8'(8'h40 + k) || inuse_count !== 9'(k < 4 ? 3 - k : 0) || rel_err !== (k == 4)) begin
        n_bad++; $display("FAIL underflow k=%0d got rv=%b rptr=%h cnt=%0d err=%b exp rv=1 rptr=%h cnt=%0d err=%b",
          k, rel_buf_valid, rel_buf_ptr, inuse_count, rel_err, 8'(8'h40 + k), k < 4 ? 3 - k : 0, k == 4);
      end
      cyc();
    end
    n_total++; if (rel_err !== 1'b1 || inuse_count !== '0) begin
      n_bad++; $display("FAIL underflow_sticky got err=%b cnt=%0d exp err=1 cnt=0", rel_err, inuse_count);
    end
  endtask

  task automatic test_reinit();
    for (int k = 0; k < 7; k++) begin
      alloc_req = NQ'(1 << (k % NQ));
      cyc();
      if (m_rd) free_buf_ptr++;
      alloc_req = '0;
      cyc();
    end
    n_total++; if (inuse_count !== 9'd7 || rel_err !== 1'b1) begin
      n_bad++; $display("FAIL reinit_pre got cnt=%0d err=%b exp cnt=7 err=1", inuse_count, rel_err);
    end
    sw_init = 1'b1;
    cyc();
    sw_init = 1'b0;
    n_total++; if (freeb_init !== 1'b1 || busy !== 1'b1) begin
      n_bad++; $display("FAIL reinit_req got finit=%b busy=%b exp 1 1", freeb_init, busy);
    end
    alloc_req = 4'b0010;
    rel_req = 2'b01;
    cyc();
    rel_req = '0;
    n_total++; if (got_rd !== 1'b0 || alloc_gnt !== '0 || rel_ack !== 2'b01 || rel_buf_valid !== 1'b0 || freeb_init !== 1'b1 || inuse_count !== 9'd7) begin
      n_bad++; $display("FAIL reinit_block got rd=%b gnt=%b ack=%b rv=%b finit=%b cnt=%0d exp 0 0000 01 0 1 7",
        got_rd, alloc_gnt, rel_ack, rel_buf_valid, freeb_init, inuse_count);
    end
    cyc();
    freeb_init_done = 1'b0;
    cyc();
    n_total++; if (freeb_init !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL reinit_wait got finit=%b busy=%b exp 0 1", freeb_init, busy);
    end
    cyc(); cyc();
    freeb_init_done = 1'b1;
    cyc();
    n_total++; if (busy !== 1'b0 || inuse_count !== '0 || rel_err !== 1'b0 || alloc_gnt !== '0) begin
      n_bad++; $display("FAIL reinit_done got busy=%b cnt=%0d err=%b gnt=%b exp 0 0 0 0000", busy, inuse_count, rel_err, alloc_gnt);
    end
    cyc();
    alloc_req = '0;
    n_total++; if (alloc_gnt !== 4'b0010 || inuse_count !== 9'd1) begin
      n_bad++; $display("FAIL reinit_resume got gnt=%b cnt=%0d exp 0010 1", alloc_gnt, inuse_count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      freeb_empty = $urandom_range(0, 3) == 0;
      free_buf_ptr = B'($urandom);
      sw_init = $urandom_range(0, 39) == 0;
      freeb_init_done = m_state == S_RQ ? 1'($urandom_range(0, 1)) :
                        m_state == S_RW ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) != 0);
      cyc();
      sw_init = 1'b0;
      n_total++; if (got_rd !== m_rd) begin n_bad++; $display("FAIL rnd_rd i=%0d got=%b exp=%b", i, got_rd, m_rd); end
      n_total++; if (alloc_gnt !== m_gnt || (m_gnt != '0 && alloc_ptr !== m_ptr)) begin
        n_bad++; $display("FAIL rnd_alloc i=%0d got gnt=%b ptr=%h exp gnt=%b ptr=%h", i, alloc_gnt, alloc_ptr, m_gnt, m_ptr);
      end
      n_total++; if (rel_ack !== m_ack || rel_buf_valid !== m_rv || (m_rv && rel_buf_ptr !== m_rptr)) begin
        n_bad++; $display("FAIL rnd_rel i=%0d got ack=%b rv=%b rptr=%h exp ack=%b rv=%b rptr=%h",
          i, rel_ack, rel_buf_valid, rel_buf_ptr, m_ack, m_rv, m_rptr);
      end
      n_total++; if (inuse_count !== (B+1)'(m_cnt) || rel_err !== m_err || freeb_init !== m_finit || busy !== (m_state != S_RUN)) begin
        n_bad++; $display("FAIL rnd_state i=%0d got cnt=%0d err=%b finit=%b busy=%b exp cnt=%0d err=%b finit=%b busy=%b",
          i, inuse_count, rel_err, freeb_init, busy, m_cnt, m_err, m_finit, m_state != S_RUN);
      end
      alloc_req &= ~m_gnt;
      rel_req &= ~m_ack;
      for (int c = 0; c < NQ; c++) if (!alloc_req[c] && $urandom_range(0, 2) == 0) alloc_req[c] = 1'b1;
      for (int c = 0; c < NL; c++) if (!rel_req[c] && $urandom_range(0, 2) == 0) begin
        rel_req[c] = 1'b1;
        rel_ptr[c*B +: B] = B'($urandom);
      end
    end
    alloc_req = '0;
    rel_req = '0;
    freeb_init_done = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
  endtask

  task automatic test_mid_reset();
    alloc_req = '1;
    rel_req = '1;
    freeb_empty = 1'b0;
    cyc();
    sw_init = 1'b1;
    rst = 1'b1;
    cyc();
    sw_init = 1'b0;
    rst = 1'b0;
    alloc_req = '0;
    rel_req = '0;
    n_total++; if ({alloc_gnt, rel_ack, rel_buf_valid, freeb_init, inuse_count, rel_err} !== '0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL mid_reset got gnt=%b ack=%b rv=%b finit=%b cnt=%0d err=%b busy=%b exp all 0 busy=1",
        alloc_gnt, rel_ack, rel_buf_valid, freeb_init, inuse_count, rel_err, busy);
    end
    cyc();
    n_total++; if (busy !== 1'b0 || freeb_init !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset_recover got busy=%b finit=%b exp 0 0", busy, freeb_init);
    end
  endtask

  initial begin
    test_reset();
    test_alloc_rr();
    test_empty();
    test_rel_collide();
    test_underflow();
    test_reinit();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
